// File: rtl/async_fifo_rd_ctrl_pkg.sv
// rtl/async_fifo_rd_ctrl_pkg.sv - shared defaults and helpers for the async FIFO pointer controllers
// Purpose: default geometry/threshold values and the binary->Gray helper used by
//          both the read-side and write-side pointer controllers.
// Ports:   none (package).
package async_fifo_rd_ctrl_pkg;

    localparam int ADDR_WIDTH_DEF      = 4;
    localparam int PTR_WIDTH_DEF       = ADDR_WIDTH_DEF + 1;
    localparam int DEPTH_DEF           = 2 ** ADDR_WIDTH_DEF;
    localparam int SYNC_STAGES_DEF     = 2;
    localparam int ALMOST_EMPTY_TH_DEF = 2;

    // Widths up to 32 bits; callers truncate to their pointer width.
    function automatic logic [31:0] bin_to_gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_to_binary_converter.sv
// rtl/gray_to_binary_converter.sv - combinational Gray to binary decode
// Purpose: binary bit i is the XOR of all Gray bits at positions >= i.
// Ports:   gray_i - Gray-coded input
//          bin_o  - binary equivalent
module gray_to_binary_converter #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/ptr_sync_chain.sv
// rtl/ptr_sync_chain.sv - multi-flop synchroniser for a Gray-coded pointer
// Purpose: carries a Gray pointer from a foreign clock domain through STAGES flops.
//          Gray coding guarantees at most one bit is in transition per sample.
// Ports:   clk_i    - destination clock
//          rst_n_i  - synchronous active-low reset, clears every stage
//          async_i  - pointer from the source domain
//          sync_o   - synchronised pointer (last stage)
module ptr_sync_chain #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// rtl/async_fifo_rd_ctrl.sv - read-domain pointer controller for the asynchronous FIFO
// Purpose: synchronises the write Gray pointer, sequences pops, drives the memory
//          read port and produces empty / almost_empty / rd_level / underflow.
// Ports:   rd_clk, rd_rst_n          - read clock, synchronous active-low reset
//          wr_ptr_gray_async         - write pointer (Gray) from the write domain
//          rd_req                    - consumer pop request
//          rd_en_mem, rd_addr        - memory read enable / address
//          rd_valid                  - read data valid (one cycle after rd_en_mem)
//          rd_ptr_gray               - registered read pointer (Gray) to write domain
//          empty, almost_empty       - registered status flags
//          rd_level                  - registered occupancy seen from the read side
//          underflow                 - one-cycle pulse for a request while empty
module async_fifo_rd_ctrl
    import async_fifo_rd_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEF,
    parameter int PTR_WIDTH       = ADDR_WIDTH + 1,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [PTR_WIDTH-1:0]  wr_ptr_gray_async,
    input  logic                  rd_req,
    output logic                  rd_en_mem,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_valid,
    output logic [PTR_WIDTH-1:0]  rd_ptr_gray,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH-1:0]  rd_level,
    output logic                  underflow
);

    logic [PTR_WIDTH-1:0] wr_gray_s;
    logic [PTR_WIDTH-1:0] wr_bin_s;

    logic [PTR_WIDTH-1:0] rd_ptr_bin_q, rd_ptr_bin_d;
    logic [PTR_WIDTH-1:0] rd_ptr_gray_q, rd_ptr_gray_d;
    logic [PTR_WIDTH-1:0] rd_level_q, rd_level_d;
    logic                 empty_q, almost_empty_q;
    logic                 rd_valid_q, underflow_q;
    logic                 pop;

    ptr_sync_chain #(
        .WIDTH  (PTR_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk_i   (rd_clk),
        .rst_n_i (rd_rst_n),
        .async_i (wr_ptr_gray_async),
        .sync_o  (wr_gray_s)
    );

    gray_to_binary_converter #(
        .WIDTH (PTR_WIDTH)
    ) u_wr_g2b (
        .gray_i (wr_gray_s),
        .bin_o  (wr_bin_s)
    );

    // A request during reset must never reach the memory port.
    assign pop = rd_req & ~empty_q & rd_rst_n;

    always_comb begin
        rd_ptr_bin_d  = rd_ptr_bin_q + {{(PTR_WIDTH-1){1'b0}}, pop};
        rd_ptr_gray_d = PTR_WIDTH'(bin_to_gray(32'(rd_ptr_bin_d)));
        // Modular difference; the wrap bit keeps full (DEPTH) apart from empty (0).
        rd_level_d    = wr_bin_s - rd_ptr_bin_d;
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_ptr_bin_q   <= '0;
            rd_ptr_gray_q  <= '0;
            rd_level_q     <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            rd_ptr_bin_q   <= rd_ptr_bin_d;
            rd_ptr_gray_q  <= rd_ptr_gray_d;
            rd_level_q     <= rd_level_d;
            // Compared against the stale synchronised pointer, so empty can only
            // be pessimistic while a write is still crossing.
            empty_q        <= (rd_ptr_gray_d == wr_gray_s);
            almost_empty_q <= (rd_level_d <= PTR_WIDTH'(ALMOST_EMPTY_TH));
            rd_valid_q     <= pop;
            underflow_q    <= rd_req & empty_q;
        end
    end

    assign rd_en_mem    = pop;
    assign rd_addr      = rd_ptr_bin_q[ADDR_WIDTH-1:0];
    assign rd_valid     = rd_valid_q;
    assign rd_ptr_gray  = rd_ptr_gray_q;
    assign empty        = empty_q;
    assign almost_empty = almost_empty_q;
    assign rd_level     = rd_level_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// tb/tb_async_fifo_rd_ctrl.sv - self-checking bench for async_fifo_rd_ctrl
module tb_async_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;
    localparam int SS    = 2;
    localparam int TH    = 2;
    localparam int PMOD  = 2 * DEPTH;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic [PW-1:0] wr_g = '0;
    logic          rd_req = 1'b0;
    logic          rd_en_mem;
    logic [AW-1:0] rd_addr;
    logic          rd_valid;
    logic [PW-1:0] rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] rd_level;
    logic          underflow;

    async_fifo_rd_ctrl #(
        .ADDR_WIDTH      (AW),
        .PTR_WIDTH       (PW),
        .SYNC_STAGES     (SS),
        .ALMOST_EMPTY_TH (TH)
    ) dut (
        .rd_clk            (rd_clk),
        .rd_rst_n          (rd_rst_n),
        .wr_ptr_gray_async (wr_g),
        .rd_req            (rd_req),
        .rd_en_mem         (rd_en_mem),
        .rd_addr           (rd_addr),
        .rd_valid          (rd_valid),
        .rd_ptr_gray       (rd_ptr_gray),
        .empty             (empty),
        .almost_empty      (almost_empty),
        .rd_level          (rd_level),
        .underflow         (underflow)
    );

    always #5 rd_clk = ~rd_clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary value whose Gray code matches.
    function automatic int from_gray(input int g);
        for (int b = 0; b < PMOD; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    // Behavioural model: integer read count, delay line for the write pointer.
    int m_rd = 0;
    int m_level = 0;
    bit m_empty = 1'b1;
    bit m_ae = 1'b1;
    bit m_valid = 1'b0;
    bit m_uf = 1'b0;
    bit m_init = 1'b0;
    int hist [SS];

    function automatic bit model_pop();
        return rd_req && rd_rst_n && !m_empty;
    endfunction

    always @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
            m_valid = 1'b0; m_uf = 1'b0; m_init = 1'b1;
            for (int i = 0; i < SS; i++) hist[i] = 0;
        end else if (m_init) begin
            int p;
            int lvl;
            p = model_pop() ? 1 : 0;
            m_uf = rd_req && m_empty;
            m_valid = (p == 1);
            m_rd = (m_rd + p) % PMOD;
            lvl = (from_gray(hist[SS-1]) - m_rd + PMOD) % PMOD;
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = int'(wr_g);
            m_level = lvl;
            m_empty = (lvl == 0);
            m_ae = (lvl <= TH);
        end
    end

    // Per-cycle comparison against the model, plus pop capture.
    int pop_q [$];
    logic [PW-1:0] prev_gray = '0;
    bit prev_rst_ok = 1'b0;

    always @(negedge rd_clk) begin
        if (m_init) begin
            chk("rd_en_mem", int'(rd_en_mem), model_pop() ? 1 : 0);
            chk("rd_addr", int'(rd_addr), m_rd % DEPTH);
            chk("rd_valid", int'(rd_valid), m_valid ? 1 : 0);
            chk("rd_ptr_gray", int'(rd_ptr_gray), to_gray(m_rd));
            chk("empty", int'(empty), m_empty ? 1 : 0);
            chk("almost_empty", int'(almost_empty), m_ae ? 1 : 0);
            chk("rd_level", int'(rd_level), m_level);
            chk("underflow", int'(underflow), m_uf ? 1 : 0);
            chk("level_range", (int'(rd_level) <= DEPTH) ? 1 : 0, 1);
            if (prev_rst_ok && rd_rst_n)
                chk("gray_one_bit", ($countones(rd_ptr_gray ^ prev_gray) <= 1) ? 1 : 0, 1);
            if (rd_en_mem) pop_q.push_back(int'(rd_addr));
        end
        prev_gray = rd_ptr_gray;
        prev_rst_ok = rd_rst_n;
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    initial begin
        // Reset
        rd_rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_empty", int'(empty), 1);
        chk("rst_almost_empty", int'(almost_empty), 1);
        chk("rst_level", int'(rd_level), 0);
        chk("rst_gray", int'(rd_ptr_gray), 0);
        chk("rst_valid", int'(rd_valid), 0);
        rd_rst_n = 1'b1;
        tick();

        // Fill to 5 then drain
        pop_q.delete();
        for (int k = 1; k <= 5; k++) begin
            wr_g = PW'(to_gray(k));
            if (k < 5) tick();
        end
        repeat (2) tick();
        chk("fill_level_at_2", int'(rd_level), 4);
        tick();
        chk("fill_level_at_3", int'(rd_level), 5);
        chk("fill_empty", int'(empty), 0);
        chk("fill_almost_empty", int'(almost_empty), 0);
        rd_req = 1'b1;
        repeat (5) tick();
        chk("drain_empty", int'(empty), 1);
        chk("drain_level", int'(rd_level), 0);
        chk("drain_last_valid", int'(rd_valid), 1);
        chk("drain_pop_count", pop_q.size(), 5);
        for (int i = 0; i < 5 && i < pop_q.size(); i++)
            chk("drain_pop_addr", pop_q[i], i);

        // Underflow
        tick();
        chk("uf1", int'(underflow), 1);
        chk("uf1_valid", int'(rd_valid), 0);
        chk("uf1_gray", int'(rd_ptr_gray), 7);
        tick();
        chk("uf2", int'(underflow), 1);
        chk("uf2_en", int'(rd_en_mem), 0);
        chk("uf2_gray", int'(rd_ptr_gray), 7);
        rd_req = 1'b0;
        tick();
        chk("uf_end", int'(underflow), 0);
        chk("uf_pop_count", pop_q.size(), 5);

        // Wrap: 20 writes interleaved with 20 pops from a fresh reset
        rd_rst_n = 1'b0;
        wr_g = '0;
        repeat (3) tick();
        rd_rst_n = 1'b1;
        tick();
        for (int i = 1; i <= 20; i++) begin
            wr_g = PW'(to_gray(i));
            repeat (3) tick();
            rd_req = 1'b1;
            tick();
            rd_req = 1'b0;
        end
        tick();
        chk("wrap_gray", int'(rd_ptr_gray), 30);
        chk("wrap_addr", int'(rd_addr), 4);
        chk("wrap_empty", int'(empty), 1);
        chk("wrap_level", int'(rd_level), 0);

        // Almost-empty threshold crossing
        wr_g = PW'(to_gray(23));
        repeat (3) tick();
        chk("th_level3", int'(rd_level), 3);
        chk("th_ae0", int'(almost_empty), 0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        chk("th_level2", int'(rd_level), 2);
        chk("th_ae1", int'(almost_empty), 1);

        // Mid-operation reset with a pending pop
        wr_g = PW'(to_gray(25));
        repeat (3) tick();
        chk("mid_level4", int'(rd_level), 4);
        rd_req = 1'b1;
        rd_rst_n = 1'b0;
        wr_g = '0;
        #1;
        chk("mid_en_in_reset", int'(rd_en_mem), 0);
        tick();
        chk("mid_empty", int'(empty), 1);
        chk("mid_ae", int'(almost_empty), 1);
        chk("mid_level", int'(rd_level), 0);
        chk("mid_gray", int'(rd_ptr_gray), 0);
        chk("mid_valid", int'(rd_valid), 0);
        chk("mid_uf", int'(underflow), 0);
        chk("mid_en", int'(rd_en_mem), 0);
        repeat (2) tick();
        rd_req = 1'b0;
        rd_rst_n = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
